// File: rtl/alu_pkg.sv
// Shared types and defaults for the two-client ALU arbiter.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 3;
    localparam int unsigned OP_W_DEF   = 2;
    localparam int unsigned RES_W_DEF  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic CLI0 = 1'b0;
    localparam logic CLI1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the previous winner loses a tie.
module rr_arb2
    import alu_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant       = CLI0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = CLI1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two clients: round-robin accept,
// hold operands for ALU_LAT edges, then return a one-cycle result pulse.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned RES_W   = RES_W_DEF,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_res,
    output logic [DATA_W-1:0] alu_portA,
    output logic [DATA_W-1:0] alu_portB,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [RES_W-1:0]  alu_out,
    output logic              busy
);

    state_t     state, state_next;
    logic       last_grant;
    logic       grant;
    logic       grant_valid;
    logic       accept;
    logic       capture;
    logic [2:0] cnt;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant_valid && (grant == CLI0) && req0_valid;
                req1_ready = grant_valid && (grant == CLI1) && req1_valid;
                accept     = req0_ready | req1_ready;
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cnt is loaded with ALU_LAT and reaches 0 after ALU_LAT edges, so the
    // capture edge lands ALU_LAT+1 edges after accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_portA  <= '0;
            alu_portB  <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_res    <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
            last_grant <= CLI1;
        end else begin
            rsp_valid <= capture;
            if (accept) begin
                if (grant == CLI0) begin
                    alu_portA  <= req0_a;
                    alu_portB  <= req0_b;
                    alu_opcode <= req0_op;
                end else begin
                    alu_portA  <= req1_a;
                    alu_portB  <= req1_b;
                    alu_opcode <= req1_op;
                end
                rsp_id     <= grant;
                last_grant <= grant;
                cnt        <= 3'(ALU_LAT);
                busy       <= 1'b1;
            end else if (capture) begin
                rsp_res <= alu_out;
                busy    <= 1'b0;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered ALU (3-bit operands, 2-bit opcode, 6-bit result) between two requesting clients.
- Arbitrates round-robin, registers and holds operands on the ALU inputs, and waits the ALU latency.
- Captures the ALU result and returns it to the winning client with a one-cycle response pulse.
- Sits between the ALU and its users; the ALU's clock and reset are shared with this block.

Parameters:
- DATA_W, 3, operand width (ALU portA/portB).
- OP_W, 2, opcode width.
- RES_W, 6, ALU result width.
- ALU_LAT, 1, clock edges from operands valid at ALU inputs to stable ALU out; range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  client 0 has an operation.
- req0_ready  out  1  client 0 operation accepted this edge when both are high.
- req0_a, req0_b  in  DATA_W  client 0 operands.
- req0_op  in  OP_W  client 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as client 0, for client 1.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  1  client owning the current response.
- rsp_res  out  RES_W  captured ALU result.
- alu_portA, alu_portB  out  DATA_W  registered operands to the ALU.
- alu_opcode  out  OP_W  registered opcode to the ALU.
- alu_out  in  RES_W  ALU result.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Reset (rst=0, async): all of the following clear to 0:
  - alu_portA, alu_portB, alu_opcode
  - rsp_valid, rsp_id, rsp_res
  - busy, wait counter
- Reset also forces: state=IDLE, last_grant=1 (client 0 wins the first tie).
- Reset mid-operation discards the in-flight op; no response is ever produced for it.
- FSM states: IDLE, WAIT.
- IDLE:
  - grant = the only valid requester.
  - If both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid; combinational from state/valids.
  - At most one ready is high per cycle; both readies are 0 in WAIT.
- Accept edge T (valid&&ready):
  - alu_portA/portB/opcode <= client's a/b/op.
  - rsp_id <= N, last_grant <= N, cnt <= ALU_LAT, busy <= 1, state <= WAIT.
- WAIT:
  - cnt decrements each edge.
  - ALU inputs are held stable for the whole WAIT state.
  - On the edge where cnt==0 (edge T+ALU_LAT+1): rsp_res <= alu_out, rsp_valid <= 1, busy <= 0, state <= IDLE.
- rsp_valid stays high exactly one cycle. There is no response backpressure; clients must sample it.
- rsp_res and rsp_id hold their values until the next capture.
- ALU operands remain driven after capture until the next accept.
- Throughput: one op per ALU_LAT+2 cycles. With ALU_LAT=1: accept edge T, rsp_valid high in cycle after T+2, next accept at T+3.
- A request whose valid drops before it is granted is simply not served; no state is kept for it.
- A requester not granted keeps its valid high and is served next: round-robin guarantees it waits at most one op.
- Widths:
  - No arithmetic on data.
  - cnt width is 3 bits.
  - rsp_res is a pure capture of alu_out (RES_W bits, no truncation).

Decomposition:
- Package alu_pkg:
  - DATA_W/OP_W/RES_W defaults.
  - state enum {IDLE, WAIT}.
  - client id constants CLI0=0, CLI1=1.
- Sub-module rr_arb2: 2-way round-robin grant.
  - Inputs: two valids, last_grant.
  - Outputs: grant id, grant_valid.
  - Purely combinational; last_grant register stays in alu_arbiter.

Test Plan:
- Bench ALU stub: registered, 1-cycle latency; op0 = a+b, op1 = a*b, op2 = a-b zero-extended, op3 = a&b.
- Single op: req0 a=4, b=3, op=1 at T → req0_ready=1 at T; rsp_valid=1, rsp_id=0, rsp_res=12 in the cycle after edge T+2; busy high during WAIT.
- Tie: req0 (4+3) and req1 (5*2) both valid from reset release → client 0 first (rsp_res=7, rsp_id=0), then client 1 (rsp_res=10, rsp_id=1), next accept 3 cycles after the first.
- Fairness: both valid continuously for 6 ops → rsp_id sequence 0,1,0,1,0,1; neither ready is high during WAIT.
- Latency parameter: ALU_LAT=3 with a 3-cycle stub, req1 a=7, b=7, op=0 → rsp_res=14 exactly 4 edges after accept; alu_portA/B/opcode stable throughout.
- Reset mid-op: accept req0 op, pull rst low during WAIT → all outputs 0 immediately; after release no rsp_valid appears; a new req1 is accepted from IDLE (rsp_id=1).
